prefetch_buffer: RTL
====================

Name: prefetch_buffer

Overview:
Second-generation instruction prefetch buffer between the fetch bus interface and the decode stage. It is a parametrised ring buffer with optional same-cycle bypass. It also tracks in-flight bus requests, so it never grants a request it could not store. Responses still in flight when a flush occurs are discarded, and each delivered word carries its fetch address.

Parameters:
DATA_WIDTH, 32, width of one fetched word; must be a multiple of 8.
ADDR_WIDTH, 32, fetch address width.
DEPTH, 4, number of buffer entries; power of two, >= 2.
MAX_OUTSTANDING, 2, maximum bus requests in flight; 1..DEPTH.
BYPASS_EN, 1, 1 = empty-buffer response may pass straight to the output in the same cycle.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
fifo_clear  input  1  flush buffer; redirect the address stream.
clear_addr  input  ADDR_WIDTH  new fetch address, sampled when fifo_clear=1.
req_allow  output  1  fetch unit may issue a bus request this cycle.
req_issue  input  1  a bus request was issued this cycle; legal only when req_allow=1.
rsp_valid  input  1  bus response data valid.
rsp_data  input  DATA_WIDTH  bus response data.
out_valid  output  1  word available to decode.
out_ready  input  1  decode accepts the word.
out_rdata  output  DATA_WIDTH  word to decode.
out_addr  output  ADDR_WIDTH  address of out_rdata.
count  output  $clog2(DEPTH)+1  number of stored entries.
rsp_err  output  1  one-cycle pulse when a response arrives with zero requests outstanding.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-high.
- Reset state: count=0, pointers=0, outstanding=0, discard=0, head address=0, rsp_err=0.
- After reset, out_valid=0 and req_allow=1.
- The outstanding counter increments on req_issue and decrements on rsp_valid. When both occur in the same cycle, it is unchanged.
- live = outstanding - discard.
- req_allow = !fifo_clear && outstanding < MAX_OUTSTANDING && (count + live) < DEPTH. This is combinational, so accepted data can never overflow the buffer.
- Discard: while discard > 0, each rsp_valid decrements discard and outstanding. The data is dropped and count is untouched.
- Accepted response: rsp_valid with discard = 0.
  - Bypass (BYPASS_EN=1, count=0, out_ready=1): the word is delivered the same cycle, with out_valid=1 and out_rdata=rsp_data. It is not written to the buffer.
  - Otherwise the word is written at the tail pointer.
- out_valid = (count > 0) || (BYPASS_EN && count == 0 && discard == 0 && rsp_valid). out_rdata comes from the head entry when count > 0.
- A pop occurs when out_valid && out_ready. On a pop, the head address advances by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH. out_addr always equals the head address.
- Pointers wrap modulo DEPTH.
- A push and pop in the same cycle leave count unchanged.
- fifo_clear (takes priority over push and pop; the output is not consumed that cycle):
  - Next state: count=0 and both pointers=0.
  - head address = clear_addr.
  - discard = outstanding + req_issue - rsp_valid. The same-cycle response is dropped.
  - out_valid is forced to 0 during the clear cycle.
  - A fifo_clear during a discard window reloads discard using the same formula.
- rsp_valid with outstanding=0 and no req_issue: rsp_err=1 for one cycle; data dropped; counters do not underflow.
- A reset mid-operation takes priority over fifo_clear and returns to the reset state. In-flight responses after reset count as rsp_err.
- Latency: a buffered word is visible on the cycle after the response. A bypassed word has zero latency.

Decomposition:
- Package prefetch_pkg:
  - PF_PTR_W = $clog2(DEPTH) and PF_CNT_W = PF_PTR_W+1 as function helpers.
  - The address increment constant DATA_WIDTH/8.
- Sub-module prefetch_ring_store: DEPTH x DATA_WIDTH register array with write-pointer write and read-pointer combinational read, no reset on data.
- Counters, discard logic, the address tracker and bypass muxing stay in prefetch_buffer.

Test Plan:
1. Reset, then issue 4 requests and return data 0xA0..0xA3 with out_ready=0 (DEPTH=4) -> count=4, req_allow=0 from the 4th issue onward; out_addr=0x0 then 0x4, 0x8, 0xC as the entries drain with out_ready=1.
2. BYPASS_EN=1, empty buffer, out_ready=1, rsp_data=0x1234 -> out_valid=1 with out_rdata=0x1234 in the same cycle; count remains 0.
3. Issue 2 requests, then fifo_clear with clear_addr=0x100 before the responses arrive -> both later responses are dropped, out_valid stays 0, and the next accepted word appears with out_addr=0x100.
4. count=2 with out_valid and out_ready=1 while rsp_valid=1 in the same cycle -> count stays 2 and the data order is preserved.
5. rsp_valid with no request outstanding -> rsp_err pulses for 1 cycle; count and outstanding remain 0.
6. Head address 0xFFFFFFFC with a pop -> out_addr wraps to 0x0. A reset asserted mid-burst -> all counters are 0 and out_valid=0 on the next cycle.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared sizing helpers for the instruction prefetch buffer.
package prefetch_pkg;

  function automatic int pf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int pf_cnt_w(input int depth);
    return pf_ptr_w(depth) + 1;
  endfunction

  // Byte stride between consecutive fetch words.
  function automatic int pf_addr_inc(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/prefetch_buffer_if.sv
// Fetch-bus and decode-side signal bundle of the prefetch buffer.
interface prefetch_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  import prefetch_pkg::*;

  localparam int CNT_W = pf_cnt_w(DEPTH);

  logic                  fifo_clear;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  req_allow;
  logic                  req_issue;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [CNT_W-1:0]      count;
  logic                  rsp_err;

  modport slave (
    input  fifo_clear, clear_addr, req_issue, rsp_valid, rsp_data, out_ready,
    output req_allow, out_valid, out_rdata, out_addr, count, rsp_err
  );

  modport master (
    output fifo_clear, clear_addr, req_issue, rsp_valid, rsp_data, out_ready,
    input  req_allow, out_valid, out_rdata, out_addr, count, rsp_err
  );

endinterface

// File: rtl/prefetch_ring_store.sv
// Ring-buffer data storage: pointer-addressed write, combinational read.
module prefetch_ring_store
  import prefetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [pf_ptr_w(DEPTH)-1:0]    wr_ptr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [pf_ptr_w(DEPTH)-1:0]    rd_ptr,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Data entries carry no reset; validity is tracked by the owner's count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr];

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch ring buffer with in-flight request tracking, flush
// discard of stale responses, optional same-cycle bypass and address tagging.
module prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BYPASS_EN       = 1
) (
  input  logic              clk,
  input  logic              reset,
  prefetch_buffer_if.slave  bus
);

  localparam int PTR_W = pf_ptr_w(DEPTH);
  localparam int CNT_W = pf_cnt_w(DEPTH);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(pf_addr_inc(DATA_WIDTH));
  localparam logic [CNT_W-1:0]      MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0]      DEPTH_S  = SUM_W'(DEPTH);
  localparam logic                  BYP      = (BYPASS_EN != 0);

  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      outstanding_r;
  logic [CNT_W-1:0]      discard_r;
  logic [ADDR_WIDTH-1:0] head_addr_r;
  logic                  rsp_err_r;

  logic [SUM_W-1:0]      room_s;
  logic                  allow_s;
  logic                  stored_s;
  logic                  orphan_s;
  logic                  accept_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  pop_store_s;
  logic                  push_s;
  logic [CNT_W-1:0]      outstanding_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  prefetch_ring_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_ptr  (wr_ptr_r),
    .wr_data (bus.rsp_data),
    .rd_ptr  (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Handshake decode: grant, accept/drop of responses, push/pop and next counts.
  always_comb begin
    room_s            = '0;
    allow_s           = 1'b0;
    stored_s          = 1'b0;
    orphan_s          = 1'b0;
    accept_s          = 1'b0;
    valid_s           = 1'b0;
    pop_s             = 1'b0;
    pop_store_s       = 1'b0;
    push_s            = 1'b0;
    outstanding_nxt_s = outstanding_r;
    count_nxt_s       = count_r;
    rdata_s           = bus.rsp_data;

    // Stored words plus live requests bound the grant, so nothing accepted can overflow.
    room_s   = SUM_W'(count_r) + SUM_W'(outstanding_r - discard_r);
    allow_s  = !bus.fifo_clear && (outstanding_r < MAX_OUT) && (room_s < DEPTH_S);
    stored_s = (count_r != '0);
    orphan_s = bus.rsp_valid && (outstanding_r == '0) && !bus.req_issue;
    accept_s = bus.rsp_valid && (discard_r == '0) && !orphan_s;

    valid_s     = !bus.fifo_clear && (stored_s || (BYP && accept_s));
    pop_s       = valid_s && bus.out_ready;
    pop_store_s = pop_s && stored_s;
    push_s      = accept_s && !bus.fifo_clear && !(BYP && !stored_s && bus.out_ready);

    outstanding_nxt_s = outstanding_r + CNT_W'(bus.req_issue)
                        - CNT_W'(bus.rsp_valid && !orphan_s);
    count_nxt_s       = count_r + CNT_W'(push_s) - CNT_W'(pop_store_s);

    if (stored_s) begin
      rdata_s = rd_data_s;
    end else begin
      rdata_s = bus.rsp_data;
    end
  end

  // Pointers, counters, discard window and head-address tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r       <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
      head_addr_r   <= '0;
      rsp_err_r     <= 1'b0;
    end else begin
      rsp_err_r     <= orphan_s;
      outstanding_r <= outstanding_nxt_s;
      if (bus.fifo_clear) begin
        // Every request still in flight after this edge returns stale data.
        count_r     <= '0;
        wr_ptr_r    <= '0;
        rd_ptr_r    <= '0;
        head_addr_r <= bus.clear_addr;
        discard_r   <= outstanding_nxt_s;
      end else begin
        count_r <= count_nxt_s;
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_store_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          head_addr_r <= head_addr_r + ADDR_INC;
        end
        if ((discard_r != '0) && bus.rsp_valid) begin
          discard_r <= discard_r - CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_allow = allow_s;
  assign bus.out_valid = valid_s;
  assign bus.out_rdata = rdata_s;
  assign bus.out_addr  = head_addr_r;
  assign bus.count     = count_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule
